mmio_bridge_multi: RTL and testbench

Parametrised memory-mapped I/O bridge for the pipelined MIPS core's M stage. It decodes CPU load/store addresses onto `NUM_TIMERS` internal countdown timers, a bridge-local interrupt pending/mask register, and the external interrupt generator port. It flags address exceptions (AdEL/AdES) and out-of-range accesses. It supersedes the fixed two-timer bridge with per-channel auto-reload mode and sticky, individually clearable interrupt sources.

---
 rtl/mmio_bridge_multi_pkg.sv | 36 +++
 rtl/mmio_bridge_multi_if.sv | 31 +++
 rtl/mmio_bridge_multi_timer_ch.sv | 96 +++++++++
 rtl/mmio_bridge_multi.sv | 160 ++++++++++++++++
 tb/tb_mmio_bridge_multi.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_bridge_multi_pkg.sv
// Shared codes for the MMIO bridge: access sizes, exception codes, timer CTRL
// layout, channel FSM states and the generator byte-enable helper.
package mmio_bridge_multi_pkg;

    localparam logic [1:0] dm_word = 2'b00;
    localparam logic [1:0] dm_half = 2'b01;
    localparam logic [1:0] dm_byte = 2'b10;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;
    localparam int CTRL_IM_BIT   = 3;
    localparam logic [3:0] CTRL_WR_MASK = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tmr_state_e;

    function automatic logic [3:0] gen_byteen(input logic [1:0] op, input logic [1:0] a);
        logic [3:0] be;
        case (op)
            dm_word: be = 4'b1111;
            dm_half: be = a[1] ? 4'b1100 : 4'b0011;
            dm_byte: be = 4'b0001 << a;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mmio_bridge_multi_if.sv
// M-stage bus between the CPU and the MMIO bridge, including the interrupt
// generator side-port and interrupt outputs.
interface mmio_bridge_multi_if;
    logic [31:0] ADDR;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        WE;
    logic [1:0]  R_W_Op;
    logic        load;
    logic        store;
    logic        exception;
    logic [4:0]  exception_type;
    logic        interrupt_IntGen;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic [5:0]  interrupt_src;
    logic        irq;
    logic        oor;

    modport slave (
        input  ADDR, WD, WE, R_W_Op, load, store, interrupt_IntGen,
        output RD, exception, exception_type, m_int_addr, m_int_byteen,
               interrupt_src, irq, oor
    );

    modport master (
        output ADDR, WD, WE, R_W_Op, load, store, interrupt_IntGen,
        input  RD, exception, exception_type, m_int_addr, m_int_byteen,
               interrupt_src, irq, oor
    );
endinterface

// File: rtl/mmio_bridge_multi_timer_ch.sv
// One countdown timer channel: CTRL/PRESET/COUNT registers and the
// IDLE/LOAD/CNT/INT sequencer that emits a one-cycle fire pulse.
module timer_ch
    import mmio_bridge_multi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ctrl,
    input  logic        wr_preset,
    input  logic [31:0] wdata,
    output logic [3:0]  ctrl,
    output logic [31:0] preset,
    output logic [31:0] count,
    output logic        fire
);

    tmr_state_e  state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        fire_q, fire_d;

    // Next-state: CPU stores land immediately, the sequencer then acts on them.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        fire_d   = 1'b0;
        if (wr_ctrl) begin
            ctrl_d = wdata[3:0] & CTRL_WR_MASK;
        end else begin
            ctrl_d = ctrl_q;
        end
        if (wr_preset) begin
            preset_d = wdata;
        end else begin
            preset_d = preset_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN_BIT]) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN_BIT]) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // PRESET of 0 lands here too, so it behaves like 1
                    count_d = 32'd0;
                    state_d = ST_INT;
                    fire_d  = 1'b1;
                end
            end
            ST_INT: begin
                if (ctrl_q[CTRL_MODE_BIT]) begin
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN_BIT] = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            fire_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            fire_q   <= fire_d;
        end
    end

    assign ctrl   = ctrl_q;
    assign preset = preset_q;
    assign count  = count_q;
    assign fire   = fire_q;

endmodule

// File: rtl/mmio_bridge_multi.sv
// M-stage MMIO bridge: decodes timers, interrupt generator and status windows,
// raises AdEL/AdES, and keeps sticky PENDING/MASK interrupt state.
module mmio_bridge_multi
    import mmio_bridge_multi_pkg::*;
#(
    parameter int          NUM_TIMERS   = 2,
    parameter logic [31:0] TIMER_BASE   = 32'h0000_7F00,
    parameter logic [31:0] TIMER_STRIDE = 32'h0000_0010,
    parameter logic [31:0] INTGEN_BASE  = 32'h0000_7F20,
    parameter logic [31:0] STATUS_BASE  = 32'h0000_7F30
)(
    input  logic clk,
    input  logic rst,
    mmio_bridge_multi_if.slave bus
);

    localparam logic [5:0] SRC_VALID = 6'((1 << (NUM_TIMERS + 1)) - 1);

    logic [31:0] ch_off_s [NUM_TIMERS];
    logic [31:0] ch_rd_s  [NUM_TIMERS];
    logic [3:0]  ch_ctrl_s [NUM_TIMERS];
    logic [31:0] ch_preset_s [NUM_TIMERS];
    logic [31:0] ch_count_s [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] hit_tmr_s, wr_ctrl_s, wr_preset_s, fire_s;

    logic [31:0] gen_off_s, stat_off_s, rd_tmr_s, rd_s;
    logic        hit_timer_s, hit_gen_s, hit_stat_s, hit_count_s, oor_s;
    logic        misalign_s, nonword_s, adel_s, ades_s, exc_s, wr_ok_s;
    logic        wr_pend_s, wr_mask_s;
    logic [4:0]  etype_s;
    logic [3:0]  byteen_s;
    logic [5:0]  set_s, clr_s;
    logic [5:0]  pending_q, pending_d, mask_q, mask_d, src_q, src_d;
    logic        intgen_q, irq_q;

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        localparam logic [31:0] CH_BASE = TIMER_BASE + TIMER_STRIDE * 32'(i);
        // Unsigned offset: addresses below the base wrap and miss the window
        assign ch_off_s[i]    = bus.ADDR - CH_BASE;
        assign hit_tmr_s[i]   = (ch_off_s[i] < 32'd12);
        assign wr_ctrl_s[i]   = wr_ok_s && hit_tmr_s[i] && (ch_off_s[i][3:2] == 2'd0);
        assign wr_preset_s[i] = wr_ok_s && hit_tmr_s[i] && (ch_off_s[i][3:2] == 2'd1);
        assign ch_rd_s[i] = !hit_tmr_s[i]               ? 32'd0 :
                            (ch_off_s[i][3:2] == 2'd0)  ? {28'd0, ch_ctrl_s[i]} :
                            (ch_off_s[i][3:2] == 2'd1)  ? ch_preset_s[i] : ch_count_s[i];

        timer_ch u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr_ctrl   (wr_ctrl_s[i]),
            .wr_preset (wr_preset_s[i]),
            .wdata     (bus.WD),
            .ctrl      (ch_ctrl_s[i]),
            .preset    (ch_preset_s[i]),
            .count     (ch_count_s[i]),
            .fire      (fire_s[i])
        );
    end

    assign gen_off_s  = bus.ADDR - INTGEN_BASE;
    assign stat_off_s = bus.ADDR - STATUS_BASE;
    assign hit_gen_s  = (gen_off_s < 32'd4);
    assign hit_stat_s = (stat_off_s < 32'd8);

    // Window decode and timer read-back reduction.
    always_comb begin
        rd_tmr_s    = 32'd0;
        hit_count_s = 1'b0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            rd_tmr_s    = rd_tmr_s | ch_rd_s[i];
            hit_count_s = hit_count_s | (hit_tmr_s[i] && (ch_off_s[i][3:2] == 2'd2));
        end
        hit_timer_s = |hit_tmr_s;
        oor_s       = !(hit_timer_s || hit_gen_s || hit_stat_s);
    end

    // Address exception detection; a faulting store is suppressed entirely.
    always_comb begin
        misalign_s = ((bus.R_W_Op == dm_word) && (bus.ADDR[1:0] != 2'b00)) ||
                     ((bus.R_W_Op == dm_half) && bus.ADDR[0]);
        nonword_s  = (hit_timer_s || hit_stat_s) && (bus.R_W_Op != dm_word);
        adel_s     = bus.load && (misalign_s || nonword_s);
        ades_s     = bus.store && (misalign_s || nonword_s || hit_count_s);
        exc_s      = adel_s || ades_s;
        if (adel_s) begin
            etype_s = EXC_ADEL;
        end else if (ades_s) begin
            etype_s = EXC_ADES;
        end else begin
            etype_s = EXC_INT;
        end
        wr_ok_s   = bus.WE && !exc_s;
        wr_pend_s = wr_ok_s && hit_stat_s && !stat_off_s[2];
        wr_mask_s = wr_ok_s && hit_stat_s && stat_off_s[2];
        if (wr_ok_s && hit_gen_s) begin
            byteen_s = gen_byteen(bus.R_W_Op, bus.ADDR[1:0]);
        end else begin
            byteen_s = 4'b0000;
        end
    end

    // Load data mux; generator and unmapped space read as zero.
    always_comb begin
        if (hit_timer_s) begin
            rd_s = rd_tmr_s;
        end else if (hit_stat_s) begin
            rd_s = stat_off_s[2] ? {26'd0, mask_q} : {26'd0, pending_q};
        end else begin
            rd_s = 32'd0;
        end
    end

    // Sticky pending: a set in the same cycle as a write-1-clear survives.
    always_comb begin
        set_s = 6'd0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            set_s[i] = fire_s[i] & ch_ctrl_s[i][CTRL_IM_BIT];
        end
        set_s[NUM_TIMERS] = bus.interrupt_IntGen & ~intgen_q;
        if (wr_pend_s) begin
            clr_s = bus.WD[5:0];
        end else begin
            clr_s = 6'd0;
        end
        pending_d = ((pending_q & ~clr_s) | set_s) & SRC_VALID;
        if (wr_mask_s) begin
            mask_d = bus.WD[5:0] & SRC_VALID;
        end else begin
            mask_d = mask_q;
        end
        src_d = pending_d & mask_d;
    end

    // Interrupt state and registered interrupt outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= 6'd0;
            mask_q    <= 6'd0;
            intgen_q  <= 1'b0;
            src_q     <= 6'd0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            intgen_q  <= bus.interrupt_IntGen;
            src_q     <= src_d;
            irq_q     <= |src_d;
        end
    end

    assign bus.RD             = rd_s;
    assign bus.exception      = exc_s;
    assign bus.exception_type = etype_s;
    assign bus.m_int_addr     = bus.ADDR;
    assign bus.m_int_byteen   = byteen_s;
    assign bus.interrupt_src  = src_q;
    assign bus.irq            = irq_q;
    assign bus.oor            = oor_s;

endmodule

// File: tb/tb_mmio_bridge_multi.sv
// Scoreboard bench for mmio_bridge_multi: a 2-timer instance at the default map
// and a 4-timer instance with its timers moved to 0x7E00.
module tb_mmio_bridge_multi;
    import mmio_bridge_multi_pkg::*;

    localparam int K_RD = 0, K_EXC = 1, K_ETYPE = 2, K_BE = 3, K_IRQ = 4;
    localparam int K_SRC = 5, K_OOR = 6, K_RD4 = 7, K_SRC4 = 8;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] addr_v, wd_v;
    logic [1:0]  op_v;
    logic        we_v, ld_v, st_v, gen_v;
    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mmio_bridge_multi_if bus2();
    mmio_bridge_multi_if bus4();

    assign bus2.ADDR = addr_v;  assign bus4.ADDR = addr_v;
    assign bus2.WD = wd_v;      assign bus4.WD = wd_v;
    assign bus2.WE = we_v;      assign bus4.WE = we_v;
    assign bus2.R_W_Op = op_v;  assign bus4.R_W_Op = op_v;
    assign bus2.load = ld_v;    assign bus4.load = ld_v;
    assign bus2.store = st_v;   assign bus4.store = st_v;
    assign bus2.interrupt_IntGen = gen_v;
    assign bus4.interrupt_IntGen = gen_v;

    mmio_bridge_multi #(.NUM_TIMERS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    mmio_bridge_multi #(.NUM_TIMERS(4), .TIMER_BASE(32'h0000_7E00))
        dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    function automatic logic [31:0] observe(input int k);
        case (k)
            K_RD:    return bus2.RD;
            K_EXC:   return {31'd0, bus2.exception};
            K_ETYPE: return {27'd0, bus2.exception_type};
            K_BE:    return {28'd0, bus2.m_int_byteen};
            K_IRQ:   return {31'd0, bus2.irq};
            K_SRC:   return {26'd0, bus2.interrupt_src};
            K_OOR:   return {31'd0, bus2.oor};
            K_RD4:   return bus4.RD;
            K_SRC4:  return {26'd0, bus4.interrupt_src};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: everything queued during a cycle is compared at its falling edge.
    initial begin
        exp_t e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = observe(e.kind);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_v(input int k, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = k; e.exp = v; e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op,
                         input logic ld, input logic st, input logic we);
        addr_v = a; wd_v = d; op_v = op; ld_v = ld; st_v = st; we_v = we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(32'h0000_0000, 32'd0, dm_word, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(a, d, dm_word, 1'b0, 1'b1, 1'b1);
        step();
        idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] v, input string n);
        drive(a, 32'd0, dm_word, 1'b1, 1'b0, 1'b0);
        expect_v(K_RD, v, n);
        step();
        idle();
    endtask

    task automatic rd4(input logic [31:0] a, input logic [31:0] v, input string n);
        drive(a, 32'd0, dm_word, 1'b1, 1'b0, 1'b0);
        expect_v(K_RD4, v, n);
        step();
        idle();
    endtask

    task automatic acc(input logic [31:0] a, input logic [1:0] op, input logic ld,
                       input logic st, input logic exc, input logic [4:0] et,
                       input logic [3:0] be, input string n);
        drive(a, 32'hA5A5_5A5A, op, ld, st, st);
        expect_v(K_EXC, {31'd0, exc}, {n, "_exc"});
        expect_v(K_ETYPE, {27'd0, et}, {n, "_type"});
        expect_v(K_BE, {28'd0, be}, {n, "_be"});
        step();
        idle();
    endtask

    initial begin
        logic [31:0] pexp;
        rst = 1'b0;
        gen_v = 1'b0;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // reset state
        expect_v(K_IRQ, 32'd0, "rst_irq");
        expect_v(K_SRC, 32'd0, "rst_src");
        rd(32'h7F00, 32'd0, "rst_ctrl0");
        rd(32'h7F08, 32'd0, "rst_count0");
        rd(32'h7F30, 32'd0, "rst_pending");
        rd(32'h7F34, 32'd0, "rst_mask");

        // one-shot, channel 0: PRESET=5, pending appears at t+8
        wr(32'h7F34, 32'h1);
        wr(32'h7F04, 32'd5);
        wr(32'h7F00, 32'h9);
        wait_cyc(6);
        rd(32'h7F30, 32'd0, "os_pend_t6");
        rd(32'h7F30, 32'd0, "os_pend_t7");
        expect_v(K_IRQ, 32'd1, "os_irq_t8");
        rd(32'h7F30, 32'd1, "os_pend_t8");
        rd(32'h7F00, 32'h8, "os_ctrl_after");
        rd(32'h7F08, 32'd0, "os_count_after");
        wr(32'h7F30, 32'h1);
        expect_v(K_IRQ, 32'd0, "os_irq_cleared");
        rd(32'h7F30, 32'd0, "os_pend_cleared");

        // auto-reload, channel 1: PRESET=3, fires at t+6, t+11, t+16
        wr(32'h7F34, 32'h2);
        wr(32'h7F14, 32'd3);
        wr(32'h7F10, 32'hB);
        wait_cyc(5);
        rd(32'h7F30, 32'd0, "ar_pend_t5");
        expect_v(K_SRC, 32'h2, "ar_src_fire1");
        wr(32'h7F30, 32'h2);
        rd(32'h7F30, 32'd0, "ar_pend_cleared");
        wait_cyc(2);
        rd(32'h7F30, 32'd0, "ar_pend_t10");
        rd(32'h7F30, 32'h2, "ar_pend_fire2");
        wait_cyc(3);
        wr(32'h7F30, 32'h2);
        rd(32'h7F30, 32'h2, "ar_set_beats_clear");
        rd(32'h7F10, 32'hB, "ar_ctrl_kept");
        wr(32'h7F10, 32'h0);
        wr(32'h7F30, 32'h3);
        rd(32'h7F30, 32'd0, "ar_pend_final");

        // EN=0 mid-count freezes COUNT
        wr(32'h7F14, 32'd50);
        wr(32'h7F10, 32'h1);
        wait_cyc(3);
        wr(32'h7F10, 32'h0);
        rd(32'h7F18, 32'd48, "stop_count_a");
        rd(32'h7F18, 32'd48, "stop_count_b");

        // address exceptions
        acc(32'h7F18, dm_word, 1'b0, 1'b1, 1'b1, EXC_ADES, 4'b0000, "sw_count");
        rd(32'h7F18, 32'd48, "sw_count_unchanged");
        acc(32'h7F04, dm_byte, 1'b0, 1'b1, 1'b1, EXC_ADES, 4'b0000, "sb_timer");
        rd(32'h7F04, 32'd5, "sb_timer_unchanged");
        acc(32'h7F00, dm_half, 1'b1, 1'b0, 1'b1, EXC_ADEL, 4'b0000, "lh_timer");
        acc(32'h7F01, dm_word, 1'b1, 1'b0, 1'b1, EXC_ADEL, 4'b0000, "lw_misalign");
        expect_v(K_OOR, 32'd1, "sw_oor_flag");
        acc(32'h8000, dm_word, 1'b0, 1'b1, 1'b0, EXC_INT, 4'b0000, "sw_oor");
        expect_v(K_OOR, 32'd0, "lw_timer_not_oor");
        acc(32'h7F04, dm_word, 1'b1, 1'b0, 1'b0, EXC_INT, 4'b0000, "lw_ok");

        // generator byte enables and rising-edge interrupt
        acc(32'h7F22, dm_byte, 1'b0, 1'b1, 1'b0, EXC_INT, 4'b0100, "sb_gen");
        acc(32'h7F22, dm_half, 1'b0, 1'b1, 1'b0, EXC_INT, 4'b1100, "sh_gen");
        acc(32'h7F20, dm_word, 1'b0, 1'b1, 1'b0, EXC_INT, 4'b1111, "sw_gen");
        acc(32'h7F21, dm_half, 1'b0, 1'b1, 1'b1, EXC_ADES, 4'b0000, "sh_gen_misalign");
        rd(32'h7F20, 32'd0, "lw_gen_zero");
        wr(32'h7F34, 32'h4);
        expect_v(K_IRQ, 32'd0, "gen_irq_before");
        gen_v = 1'b1;
        step();
        expect_v(K_IRQ, 32'd1, "gen_irq_after");
        expect_v(K_SRC, 32'h4, "gen_src_after");
        rd(32'h7F30, 32'h4, "gen_pend");

        // reset mid-count
        gen_v = 1'b0;
        wr(32'h7F04, 32'd100);
        wr(32'h7F00, 32'h1);
        wait_cyc(5);
        rd(32'h7F08, 32'd97, "mid_count");
        rst = 1'b0;
        step();
        rst = 1'b1;
        expect_v(K_IRQ, 32'd0, "rstmid_irq");
        expect_v(K_SRC, 32'd0, "rstmid_src");
        rd(32'h7F08, 32'd0, "rstmid_count");
        rd(32'h7F00, 32'd0, "rstmid_ctrl");
        wait_cyc(3);
        rd(32'h7F08, 32'd0, "rstmid_idle");

        // four channels at 0x7E00: PRESET 2/4/6/8 started on consecutive edges
        wr(32'h7F34, 32'h1F);
        wr(32'h7E04, 32'd2);
        wr(32'h7E14, 32'd4);
        wr(32'h7E24, 32'd6);
        wr(32'h7E34, 32'd8);
        wr(32'h7E00, 32'h9);
        wr(32'h7E10, 32'h9);
        wr(32'h7E20, 32'h9);
        wr(32'h7E30, 32'h9);
        for (int k = 3; k <= 15; k++) begin
            pexp = {28'd0, (k >= 14), (k >= 11), (k >= 8), (k >= 5)};
            expect_v(K_SRC4, pexp, $sformatf("t4_src_k%0d", k));
            rd4(32'h7F30, pexp, $sformatf("t4_pend_k%0d", k));
        end
        gen_v = 1'b1;
        step();
        expect_v(K_SRC4, 32'h1F, "t4_src_gen");
        rd4(32'h7E30, 32'h8, "t4_ctrl3_after");
        gen_v = 1'b0;

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
